lsu_rv32i: RTL and testbench

Memory-stage load/store unit directly downstream of the integer ALU. The ALU result is used as the effective address. The unit:
- accepts one memory op per handshake from the execute stage;
- checks alignment and op legality;
- drives a single-outstanding request/grant/response data-memory port;
- byte-aligns store data and sign- or zero-extends load data;
- presents a registered writeback result or exception.

---
 rtl/lsu_pkg.sv | 43 ++++
 rtl/lsu_align.sv | 54 +++++
 rtl/lsu_rv32i.sv | 176 +++++++++++++++++
 tb/tb_lsu_rv32i.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the RV32I load/store unit: funct3 codes, FSM state
// encoding, exception cause codes and op legality/alignment helpers.
package lsu_pkg;

    // funct3 codes (loads and stores share the size encodings)
    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StWait = 2'd2
    } lsu_state_e;

    localparam logic [1:0] CauseMisLoad  = 2'b01;
    localparam logic [1:0] CauseMisStore = 2'b10;
    localparam logic [1:0] CauseIllegal  = 2'b11;

    function automatic logic op_legal(input logic is_store, input logic [2:0] f3);
        if (is_store) begin
            return (f3 == SB) || (f3 == SH) || (f3 == SW);
        end
        return (f3 == LB) || (f3 == LH) || (f3 == LW) || (f3 == LBU) || (f3 == LHU);
    endfunction

    // Only meaningful for legal ops; f3[1:0] carries the access size.
    function automatic logic op_misaligned(input logic [2:0] f3, input logic [1:0] off);
        if (f3[1:0] == 2'b01) begin
            return off[0];
        end
        if (f3[1:0] == 2'b10) begin
            return off != 2'b00;
        end
        return 1'b0;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering for the load/store unit.
// Ports:
//   funct3_i     access size / signedness
//   offset_i     effective address bits [1:0]
//   store_data_i rs2 value
//   rdata_i      raw memory read word
//   wdata_o      lane-replicated store data
//   be_o         store byte enables
//   load_data_o  extracted and extended load data
module lsu_align
    import lsu_pkg::*;
#(
    parameter int unsigned INT32W = 32
) (
    input  logic [2:0]        funct3_i,
    input  logic [1:0]        offset_i,
    input  logic [INT32W-1:0] store_data_i,
    input  logic [INT32W-1:0] rdata_i,
    output logic [INT32W-1:0] wdata_o,
    output logic [3:0]        be_o,
    output logic [INT32W-1:0] load_data_o
);

    logic [INT32W-1:0] shifted;

    always_comb begin
        wdata_o = store_data_i;
        be_o    = 4'b1111;
        case (funct3_i)
            SB: begin
                wdata_o = {4{store_data_i[7:0]}};
                be_o    = 4'b0001 << offset_i;
            end
            SH: begin
                wdata_o = {2{store_data_i[15:0]}};
                be_o    = 4'b0011 << offset_i;
            end
            default: ;
        endcase
    end

    always_comb begin
        shifted     = rdata_i >> {offset_i, 3'b000};
        load_data_o = rdata_i;
        case (funct3_i)
            LB:      load_data_o = {{(INT32W-8){shifted[7]}}, shifted[7:0]};
            LBU:     load_data_o = {{(INT32W-8){1'b0}}, shifted[7:0]};
            LH:      load_data_o = {{(INT32W-16){shifted[15]}}, shifted[15:0]};
            LHU:     load_data_o = {{(INT32W-16){1'b0}}, shifted[15:0]};
            default: load_data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/lsu_rv32i.sv
// RV32I memory-stage load/store unit. Accepts one op per handshake, checks
// legality/alignment, runs a single-outstanding req/gnt/rvalid memory port and
// produces registered writeback, store-done or exception pulses.
// Ports: clkIn/rstIn (sync active-high), execute handshake (validIn/readyOut,
// addrIn, storeDataIn, memOpIn, rdIn), memory port (memReq/We/Addr/Wdata/Be out,
// memGnt/Rvalid/Rdata in), results (wb*, storeDoneOut, exc*).
module lsu_rv32i
    import lsu_pkg::*;
#(
    parameter int unsigned INT32W = 32,
    parameter int unsigned ADDRW  = 32
) (
    input  logic              clkIn,
    input  logic              rstIn,
    input  logic              validIn,
    output logic              readyOut,
    input  logic [ADDRW-1:0]  addrIn,
    input  logic [INT32W-1:0] storeDataIn,
    input  logic [3:0]        memOpIn,
    input  logic [4:0]        rdIn,
    output logic              memReqOut,
    output logic              memWeOut,
    output logic [ADDRW-1:0]  memAddrOut,
    output logic [INT32W-1:0] memWdataOut,
    output logic [3:0]        memBeOut,
    input  logic              memGntIn,
    input  logic              memRvalidIn,
    input  logic [INT32W-1:0] memRdataIn,
    output logic              wbValidOut,
    output logic [4:0]        wbRdOut,
    output logic [INT32W-1:0] wbDataOut,
    output logic              storeDoneOut,
    output logic              excValidOut,
    output logic [1:0]        excCauseOut,
    output logic [ADDRW-1:0]  excAddrOut
);

    lsu_state_e        state_q, state_d;
    logic [ADDRW-1:0]  addr_q, addr_d;
    logic [INT32W-1:0] data_q, data_d;
    logic              store_q, store_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [4:0]        rd_q, rd_d;
    logic              wb_valid_q, wb_valid_d;
    logic [4:0]        wb_rd_q, wb_rd_d;
    logic [INT32W-1:0] wb_data_q, wb_data_d;
    logic              store_done_q, store_done_d;
    logic              exc_valid_q, exc_valid_d;
    logic [1:0]        exc_cause_q, exc_cause_d;
    logic [ADDRW-1:0]  exc_addr_q, exc_addr_d;

    logic [INT32W-1:0] wdata;
    logic [3:0]        be;
    logic [INT32W-1:0] load_data;
    logic              in_req;

    lsu_align #(
        .INT32W(INT32W)
    ) u_align (
        .funct3_i    (funct3_q),
        .offset_i    (addr_q[1:0]),
        .store_data_i(data_q),
        .rdata_i     (memRdataIn),
        .wdata_o     (wdata),
        .be_o        (be),
        .load_data_o (load_data)
    );

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        data_d       = data_q;
        store_d      = store_q;
        funct3_d     = funct3_q;
        rd_d         = rd_q;
        wb_valid_d   = 1'b0;
        wb_rd_d      = wb_rd_q;
        wb_data_d    = wb_data_q;
        store_done_d = 1'b0;
        exc_valid_d  = 1'b0;
        exc_cause_d  = exc_cause_q;
        exc_addr_d   = exc_addr_q;

        case (state_q)
            StIdle: begin
                if (validIn) begin
                    addr_d   = addrIn;
                    data_d   = storeDataIn;
                    store_d  = memOpIn[3];
                    funct3_d = memOpIn[2:0];
                    rd_d     = rdIn;
                    // Illegal is tested first so it wins over misalignment.
                    if (!op_legal(memOpIn[3], memOpIn[2:0])) begin
                        exc_valid_d = 1'b1;
                        exc_cause_d = CauseIllegal;
                        exc_addr_d  = addrIn;
                    end else if (op_misaligned(memOpIn[2:0], addrIn[1:0])) begin
                        exc_valid_d = 1'b1;
                        exc_cause_d = memOpIn[3] ? CauseMisStore : CauseMisLoad;
                        exc_addr_d  = addrIn;
                    end else begin
                        state_d = StReq;
                    end
                end
            end
            StReq: begin
                if (memGntIn) begin
                    if (store_q) begin
                        store_done_d = 1'b1;
                        state_d      = StIdle;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (memRvalidIn) begin
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                    wb_data_d  = load_data;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            data_q       <= '0;
            store_q      <= 1'b0;
            funct3_q     <= '0;
            rd_q         <= '0;
            wb_valid_q   <= 1'b0;
            wb_rd_q      <= '0;
            wb_data_q    <= '0;
            store_done_q <= 1'b0;
            exc_valid_q  <= 1'b0;
            exc_cause_q  <= '0;
            exc_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            store_q      <= store_d;
            funct3_q     <= funct3_d;
            rd_q         <= rd_d;
            wb_valid_q   <= wb_valid_d;
            wb_rd_q      <= wb_rd_d;
            wb_data_q    <= wb_data_d;
            store_done_q <= store_done_d;
            exc_valid_q  <= exc_valid_d;
            exc_cause_q  <= exc_cause_d;
            exc_addr_q   <= exc_addr_d;
        end
    end

    // Memory-port fields are driven only while requesting so the bus idles at 0.
    assign in_req       = (state_q == StReq);
    assign readyOut     = (state_q == StIdle) && !rstIn;
    assign memReqOut    = in_req;
    assign memWeOut     = in_req && store_q;
    assign memAddrOut   = in_req ? {addr_q[ADDRW-1:2], 2'b00} : '0;
    assign memWdataOut  = (in_req && store_q) ? wdata : '0;
    assign memBeOut     = (in_req && store_q) ? be : 4'b0000;
    assign wbValidOut   = wb_valid_q;
    assign wbRdOut      = wb_rd_q;
    assign wbDataOut    = wb_data_q;
    assign storeDoneOut = store_done_q;
    assign excValidOut  = exc_valid_q;
    assign excCauseOut  = exc_cause_q;
    assign excAddrOut   = exc_addr_q;

endmodule

// File: tb/tb_lsu_rv32i.sv
// Directed self-checking bench for lsu_rv32i. Inputs change 1 time unit after
// the rising edge; outputs are sampled on the falling edge.
module tb_lsu_rv32i;

    logic        clkIn = 1'b0;
    logic        rstIn;
    logic        validIn;
    logic        readyOut;
    logic [31:0] addrIn;
    logic [31:0] storeDataIn;
    logic [3:0]  memOpIn;
    logic [4:0]  rdIn;
    logic        memReqOut;
    logic        memWeOut;
    logic [31:0] memAddrOut;
    logic [31:0] memWdataOut;
    logic [3:0]  memBeOut;
    logic        memGntIn;
    logic        memRvalidIn;
    logic [31:0] memRdataIn;
    logic        wbValidOut;
    logic [4:0]  wbRdOut;
    logic [31:0] wbDataOut;
    logic        storeDoneOut;
    logic        excValidOut;
    logic [1:0]  excCauseOut;
    logic [31:0] excAddrOut;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clkIn = ~clkIn;

    lsu_rv32i #(
        .INT32W(32),
        .ADDRW (32)
    ) dut (
        .clkIn       (clkIn),
        .rstIn       (rstIn),
        .validIn     (validIn),
        .readyOut    (readyOut),
        .addrIn      (addrIn),
        .storeDataIn (storeDataIn),
        .memOpIn     (memOpIn),
        .rdIn        (rdIn),
        .memReqOut   (memReqOut),
        .memWeOut    (memWeOut),
        .memAddrOut  (memAddrOut),
        .memWdataOut (memWdataOut),
        .memBeOut    (memBeOut),
        .memGntIn    (memGntIn),
        .memRvalidIn (memRvalidIn),
        .memRdataIn  (memRdataIn),
        .wbValidOut  (wbValidOut),
        .wbRdOut     (wbRdOut),
        .wbDataOut   (wbDataOut),
        .storeDoneOut(storeDoneOut),
        .excValidOut (excValidOut),
        .excCauseOut (excCauseOut),
        .excAddrOut  (excAddrOut)
    );

    task automatic next_cycle();
        @(posedge clkIn);
        #1;
    endtask

    // Runs one zero-wait load and reports what was seen in REQ and at writeback.
    task automatic run_load(input logic [2:0] f3, input logic [31:0] addr,
                            input logic [4:0] rd, input logic [31:0] rdata,
                            output logic req_we, output logic wb_v, output logic [4:0] wb_rd,
                            output logic [31:0] wb_d, output logic rdy, output logic wb_after);
        validIn = 1'b1; memOpIn = {1'b0, f3}; addrIn = addr; rdIn = rd;
        next_cycle();
        validIn = 1'b0; memGntIn = 1'b1;
        @(negedge clkIn);
        req_we = memWeOut;
        next_cycle();
        memGntIn = 1'b0; memRvalidIn = 1'b1; memRdataIn = rdata;
        next_cycle();
        memRvalidIn = 1'b0; memRdataIn = 32'h0;
        @(negedge clkIn);
        wb_v = wbValidOut; wb_rd = wbRdOut; wb_d = wbDataOut; rdy = readyOut;
        next_cycle();
        @(negedge clkIn);
        wb_after = wbValidOut;
    endtask

    task automatic test_reset();
        rstIn = 1'b1; validIn = 1'b0; addrIn = '0; storeDataIn = '0; memOpIn = '0;
        rdIn = '0; memGntIn = 1'b0; memRvalidIn = 1'b0; memRdataIn = '0;
        next_cycle();
        next_cycle();
        @(negedge clkIn);
        n_cmp++; if (readyOut !== 1'b0) begin n_err++;
            $display("FAIL reset_ready got %b want 0", readyOut); end
        n_cmp++; if (memReqOut !== 1'b0) begin n_err++;
            $display("FAIL reset_req got %b want 0", memReqOut); end
        n_cmp++; if ({wbValidOut, storeDoneOut, excValidOut} !== 3'b000) begin n_err++;
            $display("FAIL reset_pulses got %b want 000",
                     {wbValidOut, storeDoneOut, excValidOut}); end
        next_cycle();
        rstIn = 1'b0;
        @(negedge clkIn);
        n_cmp++; if (readyOut !== 1'b1) begin n_err++;
            $display("FAIL post_reset_ready got %b want 1", readyOut); end
        next_cycle();
    endtask

    task automatic test_store_word();
        validIn = 1'b1; memOpIn = 4'b1010; addrIn = 32'h100; storeDataIn = 32'hDEADBEEF;
        @(negedge clkIn);
        n_cmp++; if (readyOut !== 1'b1) begin n_err++;
            $display("FAIL sw_ready0 got %b want 1", readyOut); end
        next_cycle();
        validIn = 1'b0; memGntIn = 1'b1;
        @(negedge clkIn);
        n_cmp++; if ({memReqOut, memWeOut} !== 2'b11) begin n_err++;
            $display("FAIL sw_req_we got %b want 11", {memReqOut, memWeOut}); end
        n_cmp++; if (memAddrOut !== 32'h100) begin n_err++;
            $display("FAIL sw_addr got %h want 00000100", memAddrOut); end
        n_cmp++; if (memBeOut !== 4'b1111) begin n_err++;
            $display("FAIL sw_be got %b want 1111", memBeOut); end
        n_cmp++; if (memWdataOut !== 32'hDEADBEEF) begin n_err++;
            $display("FAIL sw_wdata got %h want deadbeef", memWdataOut); end
        n_cmp++; if (readyOut !== 1'b0) begin n_err++;
            $display("FAIL sw_ready1 got %b want 0", readyOut); end
        next_cycle();
        memGntIn = 1'b0;
        @(negedge clkIn);
        n_cmp++; if ({storeDoneOut, memReqOut, readyOut} !== 3'b101) begin n_err++;
            $display("FAIL sw_done got %b want 101", {storeDoneOut, memReqOut, readyOut}); end
        next_cycle();
        @(negedge clkIn);
        n_cmp++; if (storeDoneOut !== 1'b0) begin n_err++;
            $display("FAIL sw_done_pulse got %b want 0", storeDoneOut); end
    endtask

    task automatic test_store_lanes();
        logic [3:0]  ops [2]   = '{4'b1000, 4'b1001};
        logic [31:0] adr [2]   = '{32'h103, 32'h102};
        logic [31:0] dat [2]   = '{32'h000000A5, 32'h1234BEEF};
        logic [3:0]  xbe [2]   = '{4'b1000, 4'b1100};
        logic [31:0] xwd [2]   = '{32'hA5A5A5A5, 32'hBEEFBEEF};
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            validIn = 1'b1; memOpIn = ops[i]; addrIn = adr[i]; storeDataIn = dat[i];
            next_cycle();
            validIn = 1'b0; memGntIn = 1'b1;
            @(negedge clkIn);
            n_cmp++; if (memBeOut !== xbe[i]) begin n_err++;
                $display("FAIL lane%0d_be got %b want %b", i, memBeOut, xbe[i]); end
            n_cmp++; if (memWdataOut !== xwd[i]) begin n_err++;
                $display("FAIL lane%0d_wdata got %h want %h", i, memWdataOut, xwd[i]); end
            n_cmp++; if (memAddrOut !== 32'h100) begin n_err++;
                $display("FAIL lane%0d_addr got %h want 00000100", i, memAddrOut); end
            next_cycle();
            memGntIn = 1'b0;
        end
        next_cycle();
    endtask

    task automatic test_loads();
        logic [2:0]  f3s [6] = '{3'b000, 3'b100, 3'b001, 3'b001, 3'b101, 3'b010};
        logic [31:0] adr [6] = '{32'h102, 32'h102, 32'h102, 32'h100, 32'h100, 32'h104};
        logic [31:0] rdt [6] = '{32'h12805634, 32'h12805634, 32'h12805634,
                                 32'h00008001, 32'h00008001, 32'h89ABCDEF};
        logic [31:0] exd [6] = '{32'hFFFFFF80, 32'h00000080, 32'h00001280,
                                 32'hFFFF8001, 32'h00008001, 32'h89ABCDEF};
        logic        we, v, rdy, after;
        logic [4:0]  rd;
        logic [31:0] d;
        for (int i = 0; i < 6; i++) begin
            run_load(f3s[i], adr[i], (i == 5) ? 5'd0 : 5'd7, rdt[i], we, v, rd, d, rdy, after);
            n_cmp++; if (d !== exd[i]) begin n_err++;
                $display("FAIL load%0d_data got %h want %h", i, d, exd[i]); end
            if (i == 0 || i == 5) begin
                n_cmp++; if ({we, v, rdy, after} !== 4'b0110) begin n_err++;
                    $display("FAIL load%0d_we_v_rdy_after got %b want 0110", i,
                             {we, v, rdy, after}); end
                n_cmp++; if (rd !== ((i == 5) ? 5'd0 : 5'd7)) begin n_err++;
                    $display("FAIL load%0d_rd got %0d want %0d", i, rd,
                             (i == 5) ? 0 : 7); end
            end
        end
    endtask

    task automatic test_exceptions();
        logic [3:0]  ops [5] = '{4'b0001, 4'b1011, 4'b1010, 4'b0011, 4'b0110};
        logic [31:0] adr [5] = '{32'h101, 32'h100, 32'h102, 32'h101, 32'h100};
        logic [1:0]  cse [5] = '{2'b01, 2'b11, 2'b10, 2'b11, 2'b11};
        int req_seen;
        for (int i = 0; i < 5; i++) begin
            req_seen = 0;
            validIn = 1'b1; memOpIn = ops[i]; addrIn = adr[i];
            @(negedge clkIn);
            if (memReqOut) req_seen++;
            next_cycle();
            validIn = 1'b0;
            @(negedge clkIn);
            if (memReqOut) req_seen++;
            n_cmp++; if (excValidOut !== 1'b1) begin n_err++;
                $display("FAIL exc%0d_valid got %b want 1", i, excValidOut); end
            n_cmp++; if (excCauseOut !== cse[i]) begin n_err++;
                $display("FAIL exc%0d_cause got %b want %b", i, excCauseOut, cse[i]); end
            n_cmp++; if (excAddrOut !== adr[i]) begin n_err++;
                $display("FAIL exc%0d_addr got %h want %h", i, excAddrOut, adr[i]); end
            next_cycle();
            @(negedge clkIn);
            if (memReqOut) req_seen++;
            n_cmp++; if ({excValidOut, readyOut} !== 2'b01) begin n_err++;
                $display("FAIL exc%0d_pulse_ready got %b want 01", i,
                         {excValidOut, readyOut}); end
            n_cmp++; if (req_seen !== 0) begin n_err++;
                $display("FAIL exc%0d_no_req got %0d want 0", i, req_seen); end
            next_cycle();
        end
    endtask

    task automatic test_back_to_back_wait();
        int req_cnt = 0, rdy_low = 0, wb_cnt = 0, addr_bad = 0, wb_cycle = -1;
        logic [31:0] wb_d = '0;
        validIn = 1'b1; memOpIn = 4'b0010; addrIn = 32'h208; rdIn = 5'd3;
        next_cycle();
        validIn = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            memGntIn    = (c == 4);
            memRvalidIn = (c == 2) || (c == 7);
            memRdataIn  = (c == 2) ? 32'h0BADF00D : 32'h13579BDF;
            @(negedge clkIn);
            if (memReqOut) begin
                req_cnt++;
                if (memAddrOut !== 32'h208) addr_bad++;
            end
            if (!readyOut) rdy_low++;
            if (wbValidOut) begin wb_cnt++; wb_cycle = c; wb_d = wbDataOut; end
            next_cycle();
        end
        memGntIn = 1'b0; memRvalidIn = 1'b0; memRdataIn = '0;
        n_cmp++; if (req_cnt !== 4) begin n_err++;
            $display("FAIL slow_req_cycles got %0d want 4", req_cnt); end
        n_cmp++; if (addr_bad !== 0) begin n_err++;
            $display("FAIL slow_addr_unstable got %0d want 0", addr_bad); end
        n_cmp++; if (rdy_low !== 7) begin n_err++;
            $display("FAIL slow_ready_low got %0d want 7", rdy_low); end
        n_cmp++; if (wb_cnt !== 1 || wb_cycle !== 8) begin n_err++;
            $display("FAIL slow_wb count %0d cycle %0d want 1 at 8", wb_cnt, wb_cycle); end
        n_cmp++; if (wb_d !== 32'h13579BDF) begin n_err++;
            $display("FAIL slow_wb_data got %h want 13579bdf", wb_d); end
    endtask

    task automatic test_reset_mid_op();
        int wb_cnt = 0;
        // Reset while REQ is pending a grant.
        validIn = 1'b1; memOpIn = 4'b1010; addrIn = 32'h300; storeDataIn = 32'h55AA55AA;
        next_cycle();
        validIn = 1'b0;
        @(negedge clkIn);
        n_cmp++; if (memReqOut !== 1'b1) begin n_err++;
            $display("FAIL rst_req_before got %b want 1", memReqOut); end
        rstIn = 1'b1;
        next_cycle();
        rstIn = 1'b0;
        @(negedge clkIn);
        n_cmp++; if ({memReqOut, readyOut} !== 2'b01) begin n_err++;
            $display("FAIL rst_req_after got %b want 01", {memReqOut, readyOut}); end
        next_cycle();
        // Reset while WAITing for read data, then a stale rvalid arrives.
        validIn = 1'b1; memOpIn = 4'b0010; addrIn = 32'h200; rdIn = 5'd5;
        next_cycle();
        validIn = 1'b0; memGntIn = 1'b1;
        next_cycle();
        memGntIn = 1'b0; rstIn = 1'b1;
        next_cycle();
        rstIn = 1'b0; memRvalidIn = 1'b1; memRdataIn = 32'hCAFEF00D;
        for (int c = 0; c < 3; c++) begin
            @(negedge clkIn);
            if (wbValidOut) wb_cnt++;
            next_cycle();
            memRvalidIn = 1'b0;
        end
        @(negedge clkIn);
        n_cmp++; if (wb_cnt !== 0) begin n_err++;
            $display("FAIL rst_wait_wb got %0d want 0", wb_cnt); end
        n_cmp++; if ({memReqOut, memWeOut, memBeOut, storeDoneOut, excValidOut, excCauseOut}
                     !== 10'b0) begin n_err++;
            $display("FAIL rst_ctrl_zero got %b want 0",
                     {memReqOut, memWeOut, memBeOut, storeDoneOut, excValidOut, excCauseOut});
        end
        n_cmp++; if ({memAddrOut, memWdataOut, wbDataOut, excAddrOut, wbRdOut} !== 133'b0)
        begin n_err++;
            $display("FAIL rst_data_zero addr %h wdata %h wb %h exc %h rd %0d want 0",
                     memAddrOut, memWdataOut, wbDataOut, excAddrOut, wbRdOut);
        end
        n_cmp++; if (readyOut !== 1'b1) begin n_err++;
            $display("FAIL rst_wait_ready got %b want 1", readyOut); end
    endtask

    initial begin
        test_reset();
        test_store_word();
        test_store_lanes();
        test_loads();
        test_exceptions();
        test_back_to_back_wait();
        test_reset_mid_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
